// File: rtl/tri_pkg.sv
// ---------------------------------------------------------------------------
// tri_pkg
// Shared types for the projected-triangle buffer.
//   CW           : bits per screen coordinate
//   triangle_t   : [vertex][0=x,1=y][coordinate bits]
//   fifo_state_e : frame-tracking states of the buffer
// ---------------------------------------------------------------------------
package tri_pkg;

    localparam int CW = 10;

    typedef logic [2:0][1:0][CW-1:0] triangle_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fifo_state_e;

endpackage

// File: rtl/tri_signed_area.sv
// ---------------------------------------------------------------------------
// tri_signed_area
// Purely combinational signed area (doubled) of a screen-space triangle:
//   A = (x1-x0)(y2-y0) - (x2-x0)(y1-y0)
// Coordinates are treated as unsigned and zero-extended before subtraction.
// Ports:
//   i_triangle : input  [2:0][1:0][CW-1:0]  vertex[v][0]=x, [v][1]=y
//   o_area     : output signed [2*CW+1:0]   signed area, positive = front-facing
// ---------------------------------------------------------------------------
module tri_signed_area #(
    parameter int CW = 10
) (
    input  logic [2:0][1:0][CW-1:0] i_triangle,
    output logic signed [2*CW+1:0]  o_area
);

    logic signed [2*CW+1:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;

    assign w_x0 = $signed({{(CW+2){1'b0}}, i_triangle[0][0]});
    assign w_y0 = $signed({{(CW+2){1'b0}}, i_triangle[0][1]});
    assign w_x1 = $signed({{(CW+2){1'b0}}, i_triangle[1][0]});
    assign w_y1 = $signed({{(CW+2){1'b0}}, i_triangle[1][1]});
    assign w_x2 = $signed({{(CW+2){1'b0}}, i_triangle[2][0]});
    assign w_y2 = $signed({{(CW+2){1'b0}}, i_triangle[2][1]});

    assign o_area = ((w_x1 - w_x0) * (w_y2 - w_y0)) - ((w_x2 - w_x0) * (w_y1 - w_y0));

endmodule

// File: rtl/proj_tri_fifo.sv
// ---------------------------------------------------------------------------
// proj_tri_fifo
// Buffers projected triangles between the projector and the rasterizer.
// The projector never checks full, so writes while full are dropped and
// recorded in a sticky overflow flag. A small FSM follows the projector's
// proj_done level and raises frame_done once the buffer has drained.
// Optional macro TRI_FIFO_CULL_EN: drop back-facing/degenerate triangles at
// write time and count them in cull_count (tied to 0 when not defined).
// Ports:
//   Clk, Reset     : clock, synchronous active-high reset
//   fifo_w         : 1-cycle write strobe, proj_triangle valid
//   proj_triangle  : incoming triangle
//   proj_done      : level, projector finished the list
//   frame_clear    : 1-cycle synchronous flush, beats fifo_w/rd_en
//   rd_en          : pop request
//   rd_triangle    : head entry, first-word-fall-through
//   empty/full     : occupancy flags
//   count          : occupied entries
//   overflow       : sticky, write attempted while full
//   frame_done     : proj_done seen and buffer drained
//   cull_count     : triangles culled this frame
// ---------------------------------------------------------------------------
module proj_tri_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = 10
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    fifo_w,
    input  logic [2:0][1:0][CW-1:0] proj_triangle,
    input  logic                    proj_done,
    input  logic                    frame_clear,
    input  logic                    rd_en,
    output logic [2:0][1:0][CW-1:0] rd_triangle,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    frame_done,
    output logic [15:0]             cull_count
);

    import tri_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2:0][1:0][CW-1:0] r_mem [DEPTH];
    logic [AW-1:0]           r_wrPtr;
    logic [AW-1:0]           r_rdPtr;
    logic [AW:0]             r_count;
    logic                    r_overflow;
    logic                    r_frameDone;
    fifo_state_e             r_state;

    logic w_empty;
    logic w_full;
    logic w_culled;
    logic w_wrAcc;
    logic w_rdAcc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

`ifdef TRI_FIFO_CULL_EN
    logic signed [2*CW+1:0] w_area;
    logic [15:0]            r_cullCount;

    tri_signed_area #(.CW(CW)) u_area (
        .i_triangle (proj_triangle),
        .o_area     (w_area)
    );

    // Zero or negative area means back-facing or degenerate.
    assign w_culled = fifo_w && (w_area[2*CW+1] || (w_area == '0));

    always_ff @(posedge Clk) begin
        if (Reset || frame_clear) begin
            r_cullCount <= '0;
        end else if (w_culled && (r_cullCount != 16'hFFFF)) begin
            r_cullCount <= r_cullCount + 16'd1;
        end
    end

    assign cull_count = r_cullCount;
`else
    assign w_culled   = 1'b0;
    assign cull_count = '0;
`endif

    // No bypass: a read is only accepted from an already-visible entry, and
    // a full buffer drops the write even if the same cycle pops.
    assign w_wrAcc = fifo_w && !w_full && !w_culled;
    assign w_rdAcc = rd_en && !w_empty;

    // Storage is intentionally not reset.
    always_ff @(posedge Clk) begin
        if (w_wrAcc && !frame_clear) begin
            r_mem[r_wrPtr] <= proj_triangle;
        end
    end

    // Pointers and the single occupancy count that all flags derive from.
    always_ff @(posedge Clk) begin
        if (Reset || frame_clear) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_wrAcc && !w_rdAcc) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wrAcc && w_rdAcc) begin
                r_count <= r_count - 1'b1;
            end
            if (fifo_w && w_full && !w_culled) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Frame tracking; frame_done is registered alongside the state so it is
    // high exactly while the FSM sits in DONE.
    always_ff @(posedge Clk) begin
        if (Reset || frame_clear) begin
            r_state     <= IDLE;
            r_frameDone <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FILL: begin
                    if (proj_done) begin
                        if (w_empty && !w_wrAcc) begin
                            r_state     <= DONE;
                            r_frameDone <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end else if (w_wrAcc) begin
                        r_state <= FILL;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state     <= DONE;
                        r_frameDone <= 1'b1;
                    end
                end
                DONE: begin
                    if (!proj_done) begin
                        r_state     <= IDLE;
                        r_frameDone <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_frameDone <= 1'b0;
                end
            endcase
        end
    end

    assign rd_triangle = r_mem[r_rdPtr];
    assign empty       = w_empty;
    assign full        = w_full;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign frame_done  = r_frameDone;

endmodule

// File: tb/tb_proj_tri_fifo.sv
// ---------------------------------------------------------------------------
// tb_proj_tri_fifo
// Self-checking bench for proj_tri_fifo (DEPTH=16, CW=10). Expected triangles
// are queued as writes are driven and compared as entries are popped.
// ---------------------------------------------------------------------------
module tb_proj_tri_fifo;

    import tri_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        fifo_w;
    triangle_t   proj_triangle;
    logic        proj_done;
    logic        frame_clear;
    logic        rd_en;
    triangle_t   rd_triangle;
    logic        empty;
    logic        full;
    logic [4:0]  count;
    logic        overflow;
    logic        frame_done;
    logic [15:0] cull_count;

    triangle_t sbQ[$];
    int nChecks = 0;
    int nFails  = 0;

    proj_tri_fifo #(.DEPTH(16), .CW(10)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .fifo_w        (fifo_w),
        .proj_triangle (proj_triangle),
        .proj_done     (proj_done),
        .frame_clear   (frame_clear),
        .rd_en         (rd_en),
        .rd_triangle   (rd_triangle),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .overflow      (overflow),
        .frame_done    (frame_done),
        .cull_count    (cull_count)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic triangle_t mkTri(input int x0, input int y0, input int x1,
                                        input int y1, input int x2, input int y2);
        triangle_t t;
        t[0][0] = 10'(x0); t[0][1] = 10'(y0);
        t[1][0] = 10'(x1); t[1][1] = 10'(y1);
        t[2][0] = 10'(x2); t[2][1] = 10'(y2);
        return t;
    endfunction

    // Distinct front-facing triangle (area +100) tagged by n.
    function automatic triangle_t seqTri(input int n);
        return mkTri(n, n + 1, n + 10, n + 1, n, n + 11);
    endfunction

    task automatic writeTri(input triangle_t t, input bit expectStore);
        proj_triangle = t;
        fifo_w = 1'b1;
        if (expectStore) sbQ.push_back(t);
        step();
        fifo_w = 1'b0;
    endtask

    task automatic popOne(output triangle_t got);
        got = rd_triangle;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic clearFrame();
        frame_clear = 1'b1;
        step();
        frame_clear = 1'b0;
        sbQ.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        nChecks++;
        if ({empty, full, count, overflow, frame_done} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            nFails++;
            $display("[TB] FAIL reset_flags: got e=%b f=%b c=%0d o=%b d=%b, want e=1 f=0 c=0 o=0 d=0",
                     empty, full, count, overflow, frame_done);
        end
        nChecks++;
        if (cull_count !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL reset_cull: got %0d want 0", cull_count);
        end
    endtask

    task automatic test_basic();
        triangle_t got, exp;
        for (int i = 0; i < 3; i++) writeTri(seqTri(100 + i * 20), 1'b1);
        nChecks++;
        if (count !== 5'd3) begin
            nFails++;
            $display("[TB] FAIL basic_count3: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            exp = sbQ.pop_front();
            popOne(got);
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL basic_data%0d: got %h want %h", i, got, exp);
            end
            nChecks++;
            if (count !== 5'(2 - i)) begin
                nFails++;
                $display("[TB] FAIL basic_count: got %0d want %0d", count, 2 - i);
            end
        end
        nChecks++;
        if (empty !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL basic_empty: got %b want 1", empty);
        end
        // Write while empty with rd_en: write only, visible the next cycle.
        rd_en = 1'b1;
        writeTri(seqTri(300), 1'b1);
        rd_en = 1'b0;
        nChecks++;
        if (count !== 5'd1 || rd_triangle !== sbQ[0]) begin
            nFails++;
            $display("[TB] FAIL no_bypass: got count=%0d data=%h want count=1 data=%h",
                     count, rd_triangle, sbQ[0]);
        end
        popOne(got);
        exp = sbQ.pop_front();
        nChecks++;
        if (got !== exp || empty !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL no_bypass_pop: got %h empty=%b want %h empty=1", got, empty, exp);
        end
    endtask

    task automatic test_overflow();
        triangle_t got, exp;
        clearFrame();
        for (int i = 0; i < 17; i++) begin
            writeTri(seqTri(i * 5), (sbQ.size() < 16));
            if (i == 15) begin
                nChecks++;
                if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
                    nFails++;
                    $display("[TB] FAIL ovf_full16: got f=%b c=%0d o=%b want f=1 c=16 o=0",
                             full, count, overflow);
                end
            end
        end
        nChecks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            nFails++;
            $display("[TB] FAIL ovf_drop17: got o=%b c=%0d want o=1 c=16", overflow, count);
        end
        // Write while full plus pop: write is still dropped.
        proj_triangle = seqTri(400);
        fifo_w = 1'b1;
        exp = sbQ.pop_front();
        popOne(got);
        fifo_w = 1'b0;
        nChecks++;
        if (got !== exp || count !== 5'd15) begin
            nFails++;
            $display("[TB] FAIL ovf_full_rw: got %h c=%0d want %h c=15", got, count, exp);
        end
        for (int i = 0; i < 15; i++) begin
            exp = sbQ.pop_front();
            popOne(got);
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL ovf_order%0d: got %h want %h", i + 1, got, exp);
            end
        end
        nChecks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL ovf_sticky: got e=%b o=%b want e=1 o=1", empty, overflow);
        end
        clearFrame();
        nChecks++;
        if (overflow !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ovf_clear: got %b want 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        triangle_t got, exp;
        clearFrame();
        for (int i = 0; i < 4; i++) writeTri(seqTri(500 + i), 1'b1);
        for (int i = 0; i < 10; i++) begin
            exp = sbQ.pop_front();
            nChecks++;
            if (rd_triangle !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_data%0d: got %h want %h", i, rd_triangle, exp);
            end
            proj_triangle = seqTri(600 + i * 7);
            sbQ.push_back(proj_triangle);
            fifo_w = 1'b1;
            rd_en = 1'b1;
            step();
            fifo_w = 1'b0;
            rd_en = 1'b0;
            nChecks++;
            if (count !== 5'd4) begin
                nFails++;
                $display("[TB] FAIL b2b_count%0d: got %0d want 4", i, count);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exp = sbQ.pop_front();
            popOne(got);
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL b2b_tail%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    task automatic test_drain_done();
        triangle_t got;
        clearFrame();
        writeTri(seqTri(700), 1'b1);
        writeTri(seqTri(720), 1'b1);
        proj_done = 1'b1;
        step();
        step();
        nChecks++;
        if (frame_done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL drain_busy: got %b want 0", frame_done);
        end
        popOne(got);
        popOne(got);
        nChecks++;
        if (frame_done !== 1'b0 || empty !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL drain_lastpop: got d=%b e=%b want d=0 e=1", frame_done, empty);
        end
        step();
        nChecks++;
        if (frame_done !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL drain_done: got %b want 1", frame_done);
        end
        proj_done = 1'b0;
        step();
        nChecks++;
        if (frame_done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL drain_idle: got %b want 0", frame_done);
        end
        sbQ.delete();
    endtask

    task automatic test_empty_done_and_clear();
        clearFrame();
        proj_done = 1'b1;
        step();
        nChecks++;
        if (frame_done !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL empty_done: got %b want 1", frame_done);
        end
        proj_done = 1'b0;
        step();
        writeTri(seqTri(800), 1'b1);
        writeTri(seqTri(820), 1'b1);
        proj_done = 1'b1;
        step();
        // frame_clear wins over a same-cycle write.
        frame_clear = 1'b1;
        fifo_w = 1'b1;
        proj_triangle = seqTri(840);
        step();
        frame_clear = 1'b0;
        fifo_w = 1'b0;
        sbQ.delete();
        nChecks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || frame_done !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL clear_drain: got c=%0d e=%b o=%b d=%b want c=0 e=1 o=0 d=0",
                     count, empty, overflow, frame_done);
        end
        step();
        nChecks++;
        if (frame_done !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL clear_idle_done: got %b want 1", frame_done);
        end
        proj_done = 1'b0;
        step();
    endtask

    task automatic test_cull();
        triangle_t got, exp;
        bit cullOn;
        int nStore;
`ifdef TRI_FIFO_CULL_EN
        cullOn = 1'b1;
`else
        cullOn = 1'b0;
`endif
        clearFrame();
        writeTri(mkTri(0, 0, 10, 0, 0, 10), 1'b1);
        writeTri(mkTri(0, 0, 0, 10, 10, 0), !cullOn);
        writeTri(mkTri(0, 0, 5, 5, 9, 9), !cullOn);
        nStore = cullOn ? 1 : 3;
        nChecks++;
        if (count !== 5'(nStore) || cull_count !== (cullOn ? 16'd2 : 16'd0)) begin
            nFails++;
            $display("[TB] FAIL cull_counts: got c=%0d cull=%0d want c=%0d cull=%0d",
                     count, cull_count, nStore, cullOn ? 2 : 0);
        end
        for (int i = 0; i < nStore; i++) begin
            exp = sbQ.pop_front();
            popOne(got);
            nChecks++;
            if (got !== exp) begin
                nFails++;
                $display("[TB] FAIL cull_data%0d: got %h want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        fifo_w = 1'b0;
        proj_triangle = '0;
        proj_done = 1'b0;
        frame_clear = 1'b0;
        rd_en = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_drain_done();
        test_empty_done_and_clear();
        test_cull();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
